id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter CNT_W, default 16, width of the bubble counter.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  asynchronous, active-low reset.
REQ-004 stall_i  input  1  hold: retain all current outputs.
REQ-005 flush_i  input  1  squash: load a bubble (NOP) on the next edge.
REQ-006 valid_i  input  1  ID stage holds a real instruction.
REQ-007 pc_plus4_i  input  32  PC+4 of the decoded instruction.
REQ-008 rs_data_i, rt_data_i  input  32 each  register-file read data.
REQ-009 imm_ext_i  input  32  sign-extended immediate from the sign-extend unit.
REQ-010 rs_i, rt_i, rd_i  input  5 each  register specifiers.
REQ-011 ctrl_i  input  10  control bits {reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dst, alu_op[2:0]}, MSB first.
REQ-012 pc_plus4_o, rs_data_o, rt_data_o, imm_ext_o  output  32 each  registered copies.
REQ-013 rs_o, rt_o, rd_o  output  5 each  registered copies.
REQ-014 ctrl_o  output  10  registered control bits, same packing as ctrl_i.
REQ-015 valid_o  output  1  EX stage holds a real instruction.
REQ-016 bubble_cnt_o  output  CNT_W  count of bubbles inserted since reset.

Function
REQ-017 All outputs SHALL be registered; no combinational input-to-output path.
REQ-018 Update priority on each rising edge SHALL be: flush > stall > load.
REQ-019 Load (flush_i=0, stall_i=0): every *_o SHALL take its *_i value and valid_o SHALL take valid_i; latency is exactly 1 cycle.
REQ-020 Load with valid_i=0 SHALL force ctrl_o to 0 while still capturing the data fields.
REQ-021 Stall (flush_i=0, stall_i=1): all outputs, including valid_o and bubble_cnt_o, SHALL hold their values.
REQ-022 Flush (flush_i=1, stall_i ignored): valid_o, ctrl_o, and all data/specifier outputs SHALL be 0 on the next edge.
REQ-023 bubble_cnt_o SHALL increment by 1 on every edge that performs a flush or a load with valid_i=0.
REQ-024 bubble_cnt_o SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-025 imm_ext_o SHALL be passed bit-exact: no re-extension or truncation.
REQ-026 ctrl_o SHALL be 0 whenever valid_o=0, in every reachable state.

Reset
REQ-027 Assertion of rst_i (low) SHALL immediately, without waiting for a clock edge, clear all outputs to 0, including valid_o and bubble_cnt_o.
REQ-028 While rst_i is low, outputs SHALL stay 0 regardless of clk_i, stall_i, or flush_i.
REQ-029 After rst_i deasserts, the first rising edge SHALL perform a normal priority-ordered update.
REQ-030 Reset asserted mid-stall SHALL discard the held instruction; no state survives reset.

Verification
REQ-031 Load: valid_i=1, imm_ext_i=32'hFFFF_8000, ctrl_i=10'h3A5, stall_i=0, flush_i=0 -> one edge later imm_ext_o=32'hFFFF_8000, ctrl_o=10'h3A5, valid_o=1, bubble_cnt_o unchanged.
REQ-032 Stall: load as in REQ-031, then stall_i=1 for 3 cycles while the inputs change -> outputs stay at the REQ-031 values for all 3 cycles.
REQ-033 Simultaneous events: stall_i=1 and flush_i=1 on the same edge -> valid_o=0, ctrl_o=0, all data outputs 0, bubble_cnt_o +1.
REQ-034 Invalid load: valid_i=0, ctrl_i=10'h3FF, rt_data_i=32'h1234 -> ctrl_o=0, rt_data_o=32'h1234, valid_o=0, bubble_cnt_o +1.
REQ-035 Saturation: with CNT_W=4, apply 20 consecutive flushes -> bubble_cnt_o reaches 4'hF and remains 4'hF.
REQ-036 Async reset: drive rst_i low between clock edges while valid_o=1 -> all outputs read 0 before the next edge; load resumes normally after release.

Source files
------------

// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with stall, flush and bubble counter
module id_ex_reg #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [31:0]      pc_plus4_i,
    input  logic [31:0]      rs_data_i,
    input  logic [31:0]      rt_data_i,
    input  logic [31:0]      imm_ext_i,
    input  logic [4:0]       rs_i,
    input  logic [4:0]       rt_i,
    input  logic [4:0]       rd_i,
    input  logic [9:0]       ctrl_i,
    output logic [31:0]      pc_plus4_o,
    output logic [31:0]      rs_data_o,
    output logic [31:0]      rt_data_o,
    output logic [31:0]      imm_ext_o,
    output logic [4:0]       rs_o,
    output logic [4:0]       rt_o,
    output logic [4:0]       rd_o,
    output logic [9:0]       ctrl_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    logic [31:0]      pc_plus4_q, pc_plus4_d;
    logic [31:0]      rs_data_q, rs_data_d;
    logic [31:0]      rt_data_q, rt_data_d;
    logic [31:0]      imm_ext_q, imm_ext_d;
    logic [4:0]       rs_q, rs_d;
    logic [4:0]       rt_q, rt_d;
    logic [4:0]       rd_q, rd_d;
    logic [9:0]       ctrl_q, ctrl_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bubble;

    always_comb begin
        pc_plus4_d = pc_plus4_q;
        rs_data_d  = rs_data_q;
        rt_data_d  = rt_data_q;
        imm_ext_d  = imm_ext_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        rd_d       = rd_q;
        ctrl_d     = ctrl_q;
        valid_d    = valid_q;
        bubble     = 1'b0;
        if (flush_i) begin
            pc_plus4_d = '0;
            rs_data_d  = '0;
            rt_data_d  = '0;
            imm_ext_d  = '0;
            rs_d       = '0;
            rt_d       = '0;
            rd_d       = '0;
            ctrl_d     = '0;
            valid_d    = 1'b0;
            bubble     = 1'b1;
        end else if (!stall_i) begin
            pc_plus4_d = pc_plus4_i;
            rs_data_d  = rs_data_i;
            rt_data_d  = rt_data_i;
            imm_ext_d  = imm_ext_i;
            rs_d       = rs_i;
            rt_d       = rt_i;
            rd_d       = rd_i;
            // An invalid slot still captures data but must never carry live control.
            ctrl_d     = valid_i ? ctrl_i : 10'd0;
            valid_d    = valid_i;
            bubble     = !valid_i;
        end
        cnt_d = cnt_q;
        if (bubble && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_plus4_q <= '0;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_ext_q  <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            ctrl_q     <= '0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            pc_plus4_q <= pc_plus4_d;
            rs_data_q  <= rs_data_d;
            rt_data_q  <= rt_data_d;
            imm_ext_q  <= imm_ext_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
            ctrl_q     <= ctrl_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign pc_plus4_o   = pc_plus4_q;
    assign rs_data_o    = rs_data_q;
    assign rt_data_o    = rt_data_q;
    assign imm_ext_o    = imm_ext_q;
    assign rs_o         = rs_q;
    assign rt_o         = rt_q;
    assign rd_o         = rd_q;
    assign ctrl_o       = ctrl_q;
    assign valid_o      = valid_q;
    assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// tb/tb_id_ex_reg.sv - directed self-checking bench for id_ex_reg
module tb_id_ex_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, valid;
    logic [31:0] pc_i, rsd_i, rtd_i, imm_i;
    logic [4:0]  rs_i, rt_i, rd_i;
    logic [9:0]  ctrl_i;

    logic [31:0] pc_o, rsd_o, rtd_o, imm_o;
    logic [4:0]  rs_o, rt_o, rd_o;
    logic [9:0]  ctrl_o;
    logic        valid_o;
    logic [15:0] cnt_o;

    logic [31:0] pc4_o, rsd4_o, rtd4_o, imm4_o;
    logic [4:0]  rs4_o, rt4_o, rd4_o;
    logic [9:0]  ctrl4_o;
    logic        valid4_o;
    logic [3:0]  cnt4_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_ex_reg dut (
        .clk_i(clk), .rst_i(rst_n), .stall_i(stall), .flush_i(flush), .valid_i(valid),
        .pc_plus4_i(pc_i), .rs_data_i(rsd_i), .rt_data_i(rtd_i), .imm_ext_i(imm_i),
        .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .ctrl_i(ctrl_i),
        .pc_plus4_o(pc_o), .rs_data_o(rsd_o), .rt_data_o(rtd_o), .imm_ext_o(imm_o),
        .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o), .ctrl_o(ctrl_o),
        .valid_o(valid_o), .bubble_cnt_o(cnt_o)
    );

    id_ex_reg #(.CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst_n), .stall_i(stall), .flush_i(flush), .valid_i(valid),
        .pc_plus4_i(pc_i), .rs_data_i(rsd_i), .rt_data_i(rtd_i), .imm_ext_i(imm_i),
        .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .ctrl_i(ctrl_i),
        .pc_plus4_o(pc4_o), .rs_data_o(rsd4_o), .rt_data_o(rtd4_o), .imm_ext_o(imm4_o),
        .rs_o(rs4_o), .rt_o(rt4_o), .rd_o(rd4_o), .ctrl_o(ctrl4_o),
        .valid_o(valid4_o), .bubble_cnt_o(cnt4_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] rsd,
                         input logic [31:0] rtd, input logic [31:0] imm, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] c, input logic [9:0] ct);
        valid = v; pc_i = pc; rsd_i = rsd; rtd_i = rtd; imm_i = imm;
        rs_i = a; rt_i = b; rd_i = c; ctrl_i = ct;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pc"},    pc_o, 32'd0);
        chk({tag, "_rsd"},   rsd_o, 32'd0);
        chk({tag, "_rtd"},   rtd_o, 32'd0);
        chk({tag, "_imm"},   imm_o, 32'd0);
        chk({tag, "_regs"},  {17'd0, rs_o, rt_o, rd_o}, 32'd0);
        chk({tag, "_ctrl"},  {22'd0, ctrl_o}, 32'd0);
        chk({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
        chk({tag, "_cnt"},   {16'd0, cnt_o}, 32'd0);
        chk({tag, "_cnt4"},  {28'd0, cnt4_o}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(1'b1, 32'h11, 32'h22, 32'h33, 32'h44, 5'd1, 5'd2, 5'd3, 10'h155);
        step();
        chk_all_zero("reset");
        flush = 1'b1; stall = 1'b1;
        step();
        chk_all_zero("reset_hold");
        flush = 1'b0; stall = 1'b0;
        rst_n = 1'b1;

        // Basic load with negative immediate
        drive(1'b1, 32'h0000_0104, 32'hAAAA_0001, 32'hBBBB_0002, 32'hFFFF_8000,
              5'd1, 5'd2, 5'd3, 10'h3A5);
        step();
        chk("load_imm",   imm_o, 32'hFFFF_8000);
        chk("load_ctrl",  {22'd0, ctrl_o}, 32'h3A5);
        chk("load_valid", {31'd0, valid_o}, 32'd1);
        chk("load_pc",    pc_o, 32'h0000_0104);
        chk("load_rsd",   rsd_o, 32'hAAAA_0001);
        chk("load_rtd",   rtd_o, 32'hBBBB_0002);
        chk("load_regs",  {17'd0, rs_o, rt_o, rd_o}, {17'd0, 5'd1, 5'd2, 5'd3});
        chk("load_cnt",   {16'd0, cnt_o}, 32'd0);

        // Stall for three cycles while inputs move
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(i[0], 32'h900 + i, 32'h1 + i, 32'h2 + i, 32'h3 + i, 5'd9, 5'd10, 5'd11, 10'h0F0);
            step();
            chk("stall_imm",   imm_o, 32'hFFFF_8000);
            chk("stall_ctrl",  {22'd0, ctrl_o}, 32'h3A5);
            chk("stall_valid", {31'd0, valid_o}, 32'd1);
            chk("stall_pc",    pc_o, 32'h0000_0104);
            chk("stall_cnt",   {16'd0, cnt_o}, 32'd0);
        end
        stall = 1'b0;

        // Invalid load: data captured, control squashed, one bubble
        drive(1'b0, 32'h200, 32'h5, 32'h1234, 32'h7, 5'd4, 5'd5, 5'd6, 10'h3FF);
        step();
        chk("inv_ctrl",  {22'd0, ctrl_o}, 32'd0);
        chk("inv_rtd",   rtd_o, 32'h1234);
        chk("inv_valid", {31'd0, valid_o}, 32'd0);
        chk("inv_cnt",   {16'd0, cnt_o}, 32'd1);
        chk("inv_rd",    {27'd0, rd_o}, 32'd6);

        drive(1'b1, 32'h300, 32'hC0DE, 32'hBEEF, 32'h0000_7FFF, 5'd7, 5'd8, 5'd31, 10'h201);
        step();
        chk("load2_ctrl", {22'd0, ctrl_o}, 32'h201);
        chk("load2_imm",  imm_o, 32'h0000_7FFF);
        chk("load2_cnt",  {16'd0, cnt_o}, 32'd1);

        // Flush wins over stall
        stall = 1'b1; flush = 1'b1;
        step();
        chk("sf_valid", {31'd0, valid_o}, 32'd0);
        chk("sf_ctrl",  {22'd0, ctrl_o}, 32'd0);
        chk("sf_pc",    pc_o, 32'd0);
        chk("sf_rsd",   rsd_o, 32'd0);
        chk("sf_rtd",   rtd_o, 32'd0);
        chk("sf_imm",   imm_o, 32'd0);
        chk("sf_regs",  {17'd0, rs_o, rt_o, rd_o}, 32'd0);
        chk("sf_cnt",   {16'd0, cnt_o}, 32'd2);
        stall = 1'b0;

        // Saturation on the 4-bit instance; 16-bit keeps counting
        for (int i = 1; i <= 20; i++) begin
            step();
            chk("sat_cnt4", {28'd0, cnt4_o}, (2 + i > 15) ? 32'd15 : 32'(2 + i));
        end
        chk("sat_cnt16", {16'd0, cnt_o}, 32'd22);
        chk("sat_valid4", {31'd0, valid4_o}, 32'd0);
        flush = 1'b0;

        // Async reset mid-stall between edges
        drive(1'b1, 32'h400, 32'h1, 32'h2, 32'hFFFF_FFFF, 5'd1, 5'd1, 5'd1, 10'h3FF);
        step();
        chk("pre_rst_valid", {31'd0, valid_o}, 32'd1);
        chk("pre_rst_ctrl",  {22'd0, ctrl_o}, 32'h3FF);
        stall = 1'b1;
        step();
        chk("pre_rst_hold", imm_o, 32'hFFFF_FFFF);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        step();
        chk_all_zero("async_rst_edge");
        rst_n = 1'b1;
        step();
        chk("post_rst_stall_valid", {31'd0, valid_o}, 32'd0);
        stall = 1'b0;
        drive(1'b1, 32'h504, 32'h6, 32'h7, 32'hFFFF_8001, 5'd12, 5'd13, 5'd14, 10'h0A5);
        step();
        chk("resume_valid", {31'd0, valid_o}, 32'd1);
        chk("resume_ctrl",  {22'd0, ctrl_o}, 32'h0A5);
        chk("resume_imm",   imm_o, 32'hFFFF_8001);
        chk("resume_pc",    pc_o, 32'h504);
        chk("resume_cnt",   {16'd0, cnt_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
